// File: rtl/tone_arbiter.sv
// Shares the single tone PWM generator between the music stream and queued sound effects.
// Latches hit/miss requests, grants one at a time (miss first, lanes round-robin), times each SFX.
module tone_arbiter #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned SFX_LEN  = 120,
    parameter int unsigned GAP_LEN  = 10,
    parameter int unsigned SFX_F0   = 523,
    parameter int unsigned SFX_F1   = 659,
    parameter int unsigned SFX_F2   = 784,
    parameter int unsigned SFX_F3   = 1047,
    parameter int unsigned MISS_F   = 131
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] music_tone,
    input  logic        music_en,
    input  logic [3:0]  sfx_req,
    input  logic        miss_req,
    output logic [31:0] tone_out,
    output logic [1:0]  src,
    output logic [1:0]  grant_lane,
    output logic        sfx_busy,
    output logic        sfx_done
);

    localparam int unsigned MaxLen = (SFX_LEN > GAP_LEN) ? SFX_LEN : GAP_LEN;
    // A 1-bit prescaler is kept for TICK_DIV==1; it simply never leaves zero.
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(MaxLen + 1);

    localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PrescOne = PW'(1);
    localparam logic [CW-1:0] TickOne  = CW'(1);
    localparam logic [CW-1:0] SfxLast  = CW'(SFX_LEN - 1);
    localparam logic [CW-1:0] GapLast  = CW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StSfx  = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    localparam logic [1:0] SrcSilent = 2'd0;
    localparam logic [1:0] SrcMusic  = 2'd1;
    localparam logic [1:0] SrcLane   = 2'd2;
    localparam logic [1:0] SrcMiss   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] tick_q, tick_d;
    logic [3:0]    pend_q, pend_d;
    logic          pend_miss_q, pend_miss_d;
    logic [1:0]    rr_q, rr_d;
    logic [31:0]   tone_q, tone_d;
    logic [1:0]    src_q, src_d;
    logic [1:0]    lane_q, lane_d;

    logic [3:0]    clr_lane;
    logic          clr_miss;
    logic          lane_found;
    logic [1:0]    lane_sel;
    logic [1:0]    cand;
    logic          tick_end;
    logic          sfx_last;
    logic          gap_last;
    logic [31:0]   music_word;
    logic [1:0]    music_src;

    function automatic logic [31:0] lane_freq(input logic [1:0] lane);
        logic [31:0] f;
        unique case (lane)
            2'd0:    f = 32'(SFX_F0);
            2'd1:    f = 32'(SFX_F1);
            2'd2:    f = 32'(SFX_F2);
            default: f = 32'(SFX_F3);
        endcase
        return f;
    endfunction

    // Round-robin search starting at rr_q, wrapping mod 4.
    always_comb begin
        lane_found = 1'b0;
        lane_sel   = rr_q;
        cand       = rr_q;
        for (int i = 0; i < 4; i++) begin
            cand = rr_q + 2'(i);
            if (!lane_found && pend_q[cand]) begin
                lane_found = 1'b1;
                lane_sel   = cand;
            end
        end
    end

    always_comb begin
        tick_end   = (presc_q == PrescMax);
        sfx_last   = (state_q == StSfx) && tick_end && (tick_q == SfxLast);
        gap_last   = (state_q == StGap) && tick_end && (tick_q == GapLast);
        music_word = music_en ? music_tone : 32'd0;
        music_src  = music_en ? SrcMusic : SrcSilent;
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        tick_d   = tick_q;
        rr_d     = rr_q;
        tone_d   = tone_q;
        src_d    = src_q;
        lane_d   = lane_q;
        clr_lane = 4'b0000;
        clr_miss = 1'b0;

        case (state_q)
            StIdle: begin
                if (pend_miss_q) begin
                    state_d  = StSfx;
                    presc_d  = '0;
                    tick_d   = '0;
                    tone_d   = 32'(MISS_F);
                    src_d    = SrcMiss;
                    clr_miss = 1'b1;
                end else if (lane_found) begin
                    state_d            = StSfx;
                    presc_d            = '0;
                    tick_d             = '0;
                    tone_d             = lane_freq(lane_sel);
                    src_d              = SrcLane;
                    lane_d             = lane_sel;
                    rr_d               = lane_sel + 2'd1;
                    clr_lane[lane_sel] = 1'b1;
                end else begin
                    tone_d = music_word;
                    src_d  = music_src;
                end
            end

            StSfx: begin
                if (sfx_last) begin
                    presc_d = '0;
                    tick_d  = '0;
                    if (GAP_LEN == 0) begin
                        state_d = StIdle;
                        tone_d  = music_word;
                        src_d   = music_src;
                    end else begin
                        state_d = StGap;
                        tone_d  = 32'd0;
                        src_d   = SrcSilent;
                    end
                end else if (tick_end) begin
                    presc_d = '0;
                    tick_d  = tick_q + TickOne;
                end else begin
                    presc_d = presc_q + PrescOne;
                end
            end

            StGap: begin
                if (gap_last) begin
                    presc_d = '0;
                    tick_d  = '0;
                    state_d = StIdle;
                    tone_d  = music_word;
                    src_d   = music_src;
                end else if (tick_end) begin
                    presc_d = '0;
                    tick_d  = tick_q + TickOne;
                end else begin
                    presc_d = presc_q + PrescOne;
                end
            end

            default: begin
                state_d = StIdle;
                presc_d = '0;
                tick_d  = '0;
                tone_d  = 32'd0;
                src_d   = SrcSilent;
            end
        endcase

        // A new request in the grant cycle survives the clear and replays later.
        pend_d      = (pend_q & ~clr_lane) | sfx_req;
        pend_miss_d = (pend_miss_q & ~clr_miss) | miss_req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            tick_q      <= '0;
            pend_q      <= 4'b0000;
            pend_miss_q <= 1'b0;
            rr_q        <= 2'd0;
            tone_q      <= 32'd0;
            src_q       <= SrcSilent;
            lane_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            pend_q      <= pend_d;
            pend_miss_q <= pend_miss_d;
            rr_q        <= rr_d;
            tone_q      <= tone_d;
            src_q       <= src_d;
            lane_q      <= lane_d;
        end
    end

    always_comb begin
        tone_out   = tone_q;
        src        = src_q;
        grant_lane = lane_q;
        sfx_busy   = (state_q != StIdle);
        sfx_done   = sfx_last;
    end

endmodule

// File: tb/tb_tone_arbiter.sv
// Scoreboard bench for tone_arbiter: two instances (GAP_LEN=1 and GAP_LEN=0) share stimulus,
// each checked every cycle against a cycle-countdown reference model.
module tb_tone_arbiter;

    localparam int TD = 4;
    localparam int SL = 3;
    localparam int GL = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] music_tone = 32'd0;
    logic        music_en = 1'b0;
    logic [3:0]  sfx_req = 4'b0000;
    logic        miss_req = 1'b0;

    logic [31:0] tone0, tone1;
    logic [1:0]  src0, src1, lane0, lane1;
    logic        busy0, busy1, done0, done1;

    tone_arbiter #(.TICK_DIV(TD), .SFX_LEN(SL), .GAP_LEN(GL)) u_dut0 (
        .clk(clk), .reset(rst_n), .music_tone(music_tone), .music_en(music_en),
        .sfx_req(sfx_req), .miss_req(miss_req), .tone_out(tone0), .src(src0),
        .grant_lane(lane0), .sfx_busy(busy0), .sfx_done(done0)
    );

    tone_arbiter #(.TICK_DIV(TD), .SFX_LEN(SL), .GAP_LEN(0)) u_dut1 (
        .clk(clk), .reset(rst_n), .music_tone(music_tone), .music_en(music_en),
        .sfx_req(sfx_req), .miss_req(miss_req), .tone_out(tone1), .src(src1),
        .grant_lane(lane1), .sfx_busy(busy1), .sfx_done(done1)
    );

    always #5 clk = ~clk;

    // phase: 0 idle, 1 playing SFX, 2 silent gap; rem counts whole cycles left in the phase.
    typedef struct {
        int          phase;
        int          rem;
        bit [3:0]    pl;
        bit          pm;
        int          rr;
        logic [31:0] tone;
        int          src;
        int          lane;
    } mdl_t;

    typedef struct {
        logic [31:0] tone;
        int          src;
        int          lane;
        bit          busy;
        bit          done;
    } exp_t;

    mdl_t m0, m1;
    exp_t q0[$];
    exp_t q1[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.phase = 0; m.rem = 0; m.pl = 4'b0000; m.pm = 1'b0; m.rr = 0;
        m.tone = 32'd0; m.src = 0; m.lane = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m_in, input bit [3:0] req, input bit miss,
                                      input bit men, input logic [31:0] mt, input int gap_len);
        mdl_t        m;
        int          lane_f[4];
        int          found;
        int          l;
        logic [31:0] mus;
        int          msrc;
        m = m_in;
        lane_f = '{523, 659, 784, 1047};
        found = 0;
        mus = men ? mt : 32'd0;
        msrc = men ? 1 : 0;
        case (m.phase)
            0: begin
                if (m.pm) begin
                    m.pm = 1'b0; m.phase = 1; m.rem = SL * TD; m.tone = 32'd131; m.src = 3;
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        l = (m.rr + k) % 4;
                        if (found == 0 && m.pl[l]) begin
                            found = 1;
                            m.pl[l] = 1'b0;
                            m.phase = 1;
                            m.rem = SL * TD;
                            m.tone = 32'(lane_f[l]);
                            m.src = 2;
                            m.lane = l;
                            m.rr = (l + 1) % 4;
                        end
                    end
                    if (found == 0) begin
                        m.tone = mus; m.src = msrc;
                    end
                end
            end
            1: begin
                m.rem = m.rem - 1;
                if (m.rem == 0) begin
                    if (gap_len > 0) begin
                        m.phase = 2; m.rem = gap_len * TD; m.tone = 32'd0; m.src = 0;
                    end else begin
                        m.phase = 0; m.tone = mus; m.src = msrc;
                    end
                end
            end
            default: begin
                m.rem = m.rem - 1;
                if (m.rem == 0) begin
                    m.phase = 0; m.tone = mus; m.src = msrc;
                end
            end
        endcase
        m.pl = m.pl | req;
        m.pm = m.pm | miss;
        return m;
    endfunction

    function automatic exp_t mdl_exp(input mdl_t m);
        exp_t e;
        e.tone = m.tone; e.src = m.src; e.lane = m.lane;
        e.busy = (m.phase != 0);
        e.done = (m.phase == 1 && m.rem == 1);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model advances on each active edge and queues the expected outputs.
    always @(posedge clk) begin
        if (!rst_n) begin
            m0 = mdl_reset();
            m1 = mdl_reset();
        end else begin
            m0 = mdl_step(m0, sfx_req, miss_req, music_en, music_tone, GL);
            m1 = mdl_step(m1, sfx_req, miss_req, music_en, music_tone, 0);
        end
        q0.push_back(mdl_exp(m0));
        q1.push_back(mdl_exp(m1));
        cyc++;
    end

    // Monitor samples on the falling edge; an asserted reset overrides the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        exp_t z;
        z.tone = 32'd0; z.src = 0; z.lane = 0; z.busy = 1'b0; z.done = 1'b0;
        if (q0.size() == 0 || q1.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL scoreboard_empty at cycle %0d: got %0d/%0d entries, required >0",
                     cyc, q0.size(), q1.size());
        end else begin
            e = q0.pop_front();
            if (!rst_n) e = z;
            chk("gap1.tone_out", tone0, e.tone);
            chk("gap1.src", 32'(src0), 32'(e.src));
            chk("gap1.sfx_busy", 32'(busy0), 32'(e.busy));
            chk("gap1.sfx_done", 32'(done0), 32'(e.done));
            if (e.src == 2 || !rst_n) chk("gap1.grant_lane", 32'(lane0), 32'(e.lane));
            e = q1.pop_front();
            if (!rst_n) e = z;
            chk("gap0.tone_out", tone1, e.tone);
            chk("gap0.src", 32'(src1), 32'(e.src));
            chk("gap0.sfx_busy", 32'(busy1), 32'(e.busy));
            chk("gap0.sfx_done", 32'(done1), 32'(e.done));
            if (e.src == 2 || !rst_n) chk("gap0.grant_lane", 32'(lane1), 32'(e.lane));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input bit [3:0] r, input bit m);
        sfx_req = r;
        miss_req = m;
        tick(1);
        sfx_req = 4'b0000;
        miss_req = 1'b0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        music_en = 1'b1;
        music_tone = 32'd440;
        tick(6);
        music_en = 1'b0;
        tick(4);
        music_en = 1'b1;
        tick(2);

        pulse(4'b0100, 1'b0);
        tick(30);

        pulse(4'b1111, 1'b1);
        tick(110);

        // Lane 1 requested twice while lane 3 plays, then again during its own SFX.
        pulse(4'b1000, 1'b0);
        tick(3);
        pulse(4'b0010, 1'b0);
        tick(2);
        pulse(4'b0010, 1'b0);
        tick(16);
        pulse(4'b0010, 1'b0);
        tick(60);

        // Reset asserted between clock edges in the middle of an SFX with a request pending.
        pulse(4'b0100, 1'b0);
        tick(5);
        pulse(4'b0001, 1'b0);
        tick(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(30);

        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 4; b++) sfx_req[b] = ($urandom_range(0, 99) < 4);
            miss_req = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 15) == 0) music_tone = $urandom;
            music_en = ($urandom_range(0, 9) != 0);
            tick(1);
        end
        sfx_req = 4'b0000;
        miss_req = 1'b0;
        tick(150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_arbiter.md
Name: tone_arbiter

Overview:
- Shares the single tone PWM generator between the background-music tone stream and short sound effects (one per key lane plus a miss sound).
- Latches SFX requests from the game logic, grants them one at a time, and plays each for a fixed duration.
- Drives the 32-bit frequency word fed to the tone PWM generator.
- Sits between Music/PlayerCtrl and toneGen.

Parameters:
- TICK_DIV, 100000: clk cycles per duration tick (1 ms at 100 MHz).
- SFX_LEN, 120: SFX duration in ticks (≥1).
- GAP_LEN, 10: silent ticks after each SFX; 0 = no gap.
- SFX_F0, 523: lane-0 SFX frequency (Hz).
- SFX_F1, 659: lane-1 SFX frequency.
- SFX_F2, 784: lane-2 SFX frequency.
- SFX_F3, 1047: lane-3 SFX frequency.
- MISS_F, 131: miss SFX frequency.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- music_tone  in  32  current music frequency word from Music.
- music_en  in  1  1 = music may play when no SFX is active.
- sfx_req  in  4  one-cycle request pulse per key lane (hit sound).
- miss_req  in  1  one-cycle miss-sound request pulse.
- tone_out  out  32  registered frequency word to the tone PWM generator.
- src  out  2  0 silence, 1 music, 2 lane SFX, 3 miss SFX.
- grant_lane  out  2  lane currently playing (valid when src==2).
- sfx_busy  out  1  high in SFX or GAP state.
- sfx_done  out  1  one-cycle pulse on the last cycle of each SFX.

Behaviour:
- Reset (reset==0, async): tone_out=0, src=0, grant_lane=0, sfx_busy=0, sfx_done=0.
- Reset also clears the pending registers, rr pointer, tick prescaler and tick counter, and puts the FSM in IDLE. Mid-SFX reset aborts immediately, with no done pulse.
- Pending registers: pend[3:0] and pend_miss.
  - A req pulse sets its bit on the next clk edge.
  - The bit clears on the edge its request is granted.
  - Set and clear in the same cycle: set wins, so the request stays pending and replays later.
  - A req on an already-pending bit is merged into that one request.
- FSM states: IDLE, SFX, GAP.
- IDLE:
  - No pending request: tone_out<=music_en?music_tone:0 and src<=music_en?1:0. Music is passed through with 1-cycle latency and updates every cycle.
  - Any request pending: grant it, go to SFX, and load tone_out, src and grant_lane on the same edge.
- Grant priority:
  - pend_miss beats all lanes.
  - Lanes are round-robin: search from rr upward mod 4. After a lane grant, rr<=granted+1 mod 4. A miss grant leaves rr unchanged.
- Latency: a req pulse in cycle N (FSM idle, nothing pending) sets pend at edge N+1 and puts the SFX tone on tone_out at edge N+2.
- SFX:
  - tone_out holds the selected SFX_Fx or MISS_F; music_tone is ignored.
  - The prescaler restarts at grant, so the SFX lasts exactly SFX_LEN*TICK_DIV cycles.
  - sfx_done is high in the final SFX cycle.
  - Next state is GAP, or IDLE if GAP_LEN==0.
- GAP: tone_out=0, src=0, sfx_busy=1 for GAP_LEN*TICK_DIV cycles, then IDLE.
- After SFX or GAP, IDLE re-arbitrates on its first cycle. Back-to-back SFX with GAP_LEN==0 therefore have one IDLE cycle between them, during which music or silence is output.
- Requests arriving during SFX or GAP are only latched. There is no preemption, including by miss.
- Width rules:
  - Prescaler width is clog2(TICK_DIV).
  - Tick counter width is clog2(max(SFX_LEN,GAP_LEN)+1).
  - tone_out is 32 bits; the parameters are zero-extended.

Test Plan (TICK_DIV=4, SFX_LEN=3, GAP_LEN=1):
- Idle passthrough:
  - Stimulus: reset, then music_en=1, music_tone=440.
  - Response: tone_out=440, src=1 one cycle later. With music_en=0, tone_out=0 and src=0.
- Single hit:
  - Stimulus: sfx_req=4'b0100 pulsed in cycle N.
  - Response: at edge N+2, tone_out=784, src=2, grant_lane=2.
  - Response: 12 cycles of SFX with sfx_done high in the 12th, then 4 cycles of tone_out=0 with sfx_busy=1, then back to 440.
- Round-robin plus miss priority:
  - Stimulus: sfx_req=4'b1111 and miss_req=1 in the same cycle.
  - Response: play order MISS(131), then lanes 0,1,2,3 (523, 659, 784, 1047), with rr=0 at the end.
- Merge and re-request:
  - Stimulus: lane 1 pulsed twice while lane 3 plays.
  - Response: lane 1 plays once afterwards.
  - Stimulus: lane 1 pulsed again during its own SFX.
  - Response: lane 1 plays a second time after the GAP.
- Async reset mid-SFX:
  - Stimulus: reset=0 asserted mid-cycle during the SFX.
  - Response: tone_out=0, src=0, sfx_busy=0 immediately, with no sfx_done pulse.
  - Response: after release, pending requests are gone and only music plays.
- GAP_LEN=0 variant:
  - Stimulus: two lane requests pending.
  - Response: SFX, one IDLE cycle outputting music, then SFX.
